// File: rtl/lpc_io_cycle_ctrl_if.sv
// LPC pin and register-file signals seen by the LPC I/O cycle controller.
// The controller connects through the slave modport; the host/pad side uses master.
interface lpc_io_cycle_ctrl_if;
    logic       LFrame_n;
    logic [3:0] LAD_in;
    logic [3:0] LAD_out;
    logic       LAD_oe;
    logic [7:0] RdData;
    logic [7:0] Addr;
    logic       Wr;
    logic [7:0] DataWr;

    modport slave (
        input  LFrame_n, LAD_in, RdData,
        output LAD_out, LAD_oe, Addr, Wr, DataWr
    );

    modport master (
        output LFrame_n, LAD_in, RdData,
        input  LAD_out, LAD_oe, Addr, Wr, DataWr
    );
endinterface

// File: rtl/lpc_io_cycle_ctrl.sv
// LPC slave front end: decodes host I/O read/write cycles into a 32-byte register window
// and returns read data on LAD. Every pad and register-file output is a flop.
module lpc_io_cycle_ctrl #(
    parameter logic [15:0] BASE_ADDR = 16'h0800,
    parameter int unsigned SYNC_WAIT = 0
) (
    input  logic               LpcClock,
    input  logic               PciReset,
    lpc_io_cycle_ctrl_if.slave bus
);

    typedef enum logic [3:0] {
        IDLE, CYC, ADR3, ADR2, ADR1, ADR0, DIN0, DIN1,
        HTAR0, HTAR1, SYNC, DOUT0, DOUT1, PTAR0, PTAR1
    } state_e;

    localparam logic [2:0] SyncLast = SYNC_WAIT[2:0];

    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] ioaddr_q, ioaddr_d;
    logic [7:0]  data_q, data_d;
    logic        write_q, write_d;
    logic [7:0]  addr_q, addr_d;
    logic [3:0]  lad_out_q, lad_out_d;
    logic        lad_oe_q, lad_oe_d;
    logic        wr_q, wr_d;
    logic [7:0]  data_wr_q, data_wr_d;

    always_comb begin
        // NOTE: every _d gets a default first, so no path through this block can infer a latch.
        state_d   = state_q;
        cnt_d     = cnt_q;
        ioaddr_d  = ioaddr_q;
        data_d    = data_q;
        write_d   = write_q;
        addr_d    = addr_q;
        lad_out_d = 4'hF;
        lad_oe_d  = 1'b0;
        wr_d      = 1'b0;
        data_wr_d = data_wr_q;

        if (!bus.LFrame_n) begin
            // START or abort: the host owns the bus again, whatever we were doing.
            state_d = (bus.LAD_in == 4'b0000) ? CYC : IDLE;
        end else begin
            unique case (state_q)
                IDLE: state_d = IDLE;
                CYC: begin
                    if (bus.LAD_in[3:1] == 3'b000) begin
                        write_d = 1'b0;
                        state_d = ADR3;
                    end else if (bus.LAD_in[3:1] == 3'b001) begin
                        write_d = 1'b1;
                        state_d = ADR3;
                    end else begin
                        state_d = IDLE;
                    end
                end
                ADR3: begin
                    ioaddr_d = {ioaddr_q[11:0], bus.LAD_in};
                    state_d  = ADR2;
                end
                ADR2: begin
                    ioaddr_d = {ioaddr_q[11:0], bus.LAD_in};
                    state_d  = ADR1;
                end
                ADR1: begin
                    ioaddr_d = {ioaddr_q[11:0], bus.LAD_in};
                    state_d  = ADR0;
                end
                ADR0: begin
                    ioaddr_d = {ioaddr_q[11:0], bus.LAD_in};
                    if (ioaddr_d[15:5] == BASE_ADDR[15:5]) begin
                        addr_d  = {3'b000, ioaddr_d[4:0]};
                        state_d = write_q ? DIN0 : HTAR0;
                    end else begin
                        state_d = IDLE;
                    end
                end
                DIN0: begin
                    data_d  = {data_q[7:4], bus.LAD_in};
                    state_d = DIN1;
                end
                DIN1: begin
                    data_d  = {bus.LAD_in, data_q[3:0]};
                    state_d = HTAR0;
                end
                HTAR0: state_d = HTAR1;
                HTAR1: begin
                    // Addr has been stable since HTAR0, so RdData has settled by now.
                    if (!write_q) data_d = bus.RdData;
                    cnt_d   = 3'd0;
                    state_d = SYNC;
                end
                SYNC: begin
                    if (cnt_q == SyncLast) state_d = write_q ? PTAR0 : DOUT0;
                    else                   cnt_d   = cnt_q + 3'd1;
                end
                DOUT0: state_d = DOUT1;
                DOUT1: state_d = PTAR0;
                PTAR0: state_d = PTAR1;
                PTAR1: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end

        // Outputs are decoded from the next state so they line up with it once registered.
        unique case (state_d)
            SYNC: begin
                lad_oe_d  = 1'b1;
                lad_out_d = (cnt_d == SyncLast) ? 4'b0000 : 4'b0110;
                if (write_d && cnt_d == SyncLast) begin
                    wr_d      = 1'b1;
                    data_wr_d = data_d;
                end
            end
            DOUT0: begin
                lad_oe_d  = 1'b1;
                lad_out_d = data_d[3:0];
            end
            DOUT1: begin
                lad_oe_d  = 1'b1;
                lad_out_d = data_d[7:4];
            end
            PTAR0: lad_oe_d = 1'b1;
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge LpcClock) begin
        if (PciReset) begin
            state_q   <= IDLE;
            cnt_q     <= 3'd0;
            ioaddr_q  <= 16'h0000;
            data_q    <= 8'h00;
            write_q   <= 1'b0;
            addr_q    <= 8'h00;
            lad_out_q <= 4'hF;
            lad_oe_q  <= 1'b0;
            wr_q      <= 1'b0;
            data_wr_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ioaddr_q  <= ioaddr_d;
            data_q    <= data_d;
            write_q   <= write_d;
            addr_q    <= addr_d;
            lad_out_q <= lad_out_d;
            lad_oe_q  <= lad_oe_d;
            wr_q      <= wr_d;
            data_wr_q <= data_wr_d;
        end
    end

    assign bus.LAD_out = lad_out_q;
    assign bus.LAD_oe  = lad_oe_q;
    assign bus.Addr    = addr_q;
    assign bus.Wr      = wr_q;
    assign bus.DataWr  = data_wr_q;

endmodule
